// File: rtl/dpi_test_objection_ctrl.sv
// End-of-test controller: per-agent objection counters, drain timer, timeout
// watchdog and a sticky registered pass/fail verdict with a 64-bit code.
module dpi_test_objection_ctrl #(
  parameter int NUM_AGENTS     = 4,
  parameter int OBJ_W          = 8,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int AW    = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1,
  localparam int OUT_W = OBJ_W + AW
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_AGENTS-1:0]   obj_raise,
  input  logic [NUM_AGENTS-1:0]   obj_drop,
  input  logic [NUM_AGENTS-1:0]   done_valid,
  input  logic [64*NUM_AGENTS-1:0] done_code,
  output logic                    finish,
  output logic                    passed,
  output logic [63:0]             fail_code,
  output logic [AW-1:0]           finish_agent,
  output logic [2:0]              state,
  output logic [OUT_W-1:0]        outstanding,
  output logic [63:0]             cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [63:0] CODE_UNDER   = 64'hE000_0000_0000_0000;
  localparam logic [63:0] CODE_OVER    = 64'hE100_0000_0000_0000;
  localparam logic [63:0] CODE_TIMEOUT = 64'hE200_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUNNING = 3'd1,
    DRAIN   = 3'd2,
    DONE    = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [OBJ_W-1:0] cnt_q [NUM_AGENTS];
  logic [OBJ_W-1:0] cnt_d [NUM_AGENTS];
  logic [DW-1:0]    drain_q, drain_d;
  logic [OUT_W-1:0] sum_d;

  logic             err_hit;
  logic [63:0]      err_code;
  logic [AW-1:0]    err_agent;
  logic             done_any, done_fail, pass_found;
  logic [63:0]      done_fail_code;
  logic [AW-1:0]    done_fail_agent, pass_agent;
  logic             timeout_hit;

  logic             finish_d, passed_d;
  logic [63:0]      code_d;
  logic [AW-1:0]    agent_d;

  // Counter update plus error detection; lowest erroring agent is reported.
  always_comb begin
    sum_d     = '0;
    err_hit   = 1'b0;
    err_code  = '0;
    err_agent = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (obj_raise[i] && !obj_drop[i]) begin
        if (&cnt_q[i]) begin
          if (!err_hit) begin
            err_hit   = 1'b1;
            err_code  = CODE_OVER | 64'(i);
            err_agent = AW'(i);
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (obj_drop[i] && !obj_raise[i]) begin
        if (cnt_q[i] == '0) begin
          if (!err_hit) begin
            err_hit   = 1'b1;
            err_code  = CODE_UNDER | 64'(i);
            err_agent = AW'(i);
          end
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
      sum_d = sum_d + OUT_W'(cnt_d[i]);
    end
  end

  // A nonzero code from any asserted agent outranks every zero code.
  always_comb begin
    done_any        = |done_valid;
    done_fail       = 1'b0;
    done_fail_code  = '0;
    done_fail_agent = '0;
    pass_found      = 1'b0;
    pass_agent      = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (done_valid[i]) begin
        if (!done_fail && (done_code[64*i +: 64] != 64'd0)) begin
          done_fail       = 1'b1;
          done_fail_code  = done_code[64*i +: 64];
          done_fail_agent = AW'(i);
        end
        if (!pass_found) begin
          pass_found = 1'b1;
          pass_agent = AW'(i);
        end
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cycle_count == 64'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    finish_d = finish;
    passed_d = passed;
    code_d   = fail_code;
    agent_d  = finish_agent;
    if (state_q != DONE) begin
      if (done_any) begin
        state_d  = DONE;
        finish_d = 1'b1;
        if (done_fail) begin
          passed_d = 1'b0;
          code_d   = done_fail_code;
          agent_d  = done_fail_agent;
        end else begin
          passed_d = 1'b1;
          code_d   = '0;
          agent_d  = pass_agent;
        end
      end else if (err_hit) begin
        state_d  = DONE;
        finish_d = 1'b1;
        passed_d = 1'b0;
        code_d   = err_code;
        agent_d  = err_agent;
      end else if (timeout_hit) begin
        state_d  = DONE;
        finish_d = 1'b1;
        passed_d = 1'b0;
        code_d   = CODE_TIMEOUT;
        agent_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sum_d != '0) state_d = RUNNING;
          end
          RUNNING: begin
            if (sum_d == '0) begin
              state_d = DRAIN;
              drain_d = DW'(DRAIN_CYCLES);
            end
          end
          DRAIN: begin
            // A fresh objection outranks a drain that would expire this cycle.
            if (sum_d != '0) begin
              state_d = RUNNING;
            end else if (drain_q <= DW'(1)) begin
              state_d  = DONE;
              finish_d = 1'b1;
              passed_d = 1'b1;
              code_d   = '0;
              agent_d  = '0;
            end else begin
              drain_d = drain_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      for (int i = 0; i < NUM_AGENTS; i++) cnt_q[i] <= '0;
      outstanding  <= '0;
      cycle_count  <= '0;
      finish       <= 1'b0;
      passed       <= 1'b0;
      fail_code    <= '0;
      finish_agent <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      finish       <= finish_d;
      passed       <= passed_d;
      fail_code    <= code_d;
      finish_agent <= agent_d;
      if (state_q != DONE) begin
        cnt_q       <= cnt_d;
        outstanding <= sum_d;
        cycle_count <= cycle_count + 64'd1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_dpi_test_objection_ctrl.sv
// Bench for dpi_test_objection_ctrl: two parameterisations share stimulus and
// are checked against a behavioural model plus directed constant checks.
module tb_dpi_test_objection_ctrl;
  localparam int NA = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NA-1:0]    obj_raise  = '0;
  logic [NA-1:0]    obj_drop   = '0;
  logic [NA-1:0]    done_valid = '0;
  logic [64*NA-1:0] done_code  = '0;

  logic        finish_a, passed_a, finish_b, passed_b;
  logic [63:0] fail_code_a, fail_code_b, cycle_a, cycle_b;
  logic [1:0]  agent_a, agent_b;
  logic [2:0]  state_a, state_b;
  logic [9:0]  outstanding_a;
  logic [3:0]  outstanding_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dpi_test_objection_ctrl #(.NUM_AGENTS(NA), .OBJ_W(8), .DRAIN_CYCLES(16),
                            .TIMEOUT_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .obj_raise(obj_raise), .obj_drop(obj_drop),
    .done_valid(done_valid), .done_code(done_code), .finish(finish_a),
    .passed(passed_a), .fail_code(fail_code_a), .finish_agent(agent_a),
    .state(state_a), .outstanding(outstanding_a), .cycle_count(cycle_a));

  dpi_test_objection_ctrl #(.NUM_AGENTS(NA), .OBJ_W(2), .DRAIN_CYCLES(3),
                            .TIMEOUT_CYCLES(100)) dut_b (
    .clock(clock), .reset(reset), .obj_raise(obj_raise), .obj_drop(obj_drop),
    .done_valid(done_valid), .done_code(done_code), .finish(finish_b),
    .passed(passed_b), .fail_code(fail_code_b), .finish_agent(agent_b),
    .state(state_b), .outstanding(outstanding_b), .cycle_count(cycle_b));

  // Reference model: index 0 mirrors dut_a's parameters, index 1 dut_b's.
  int          p_max   [2] = '{255, 3};
  int          p_drain [2] = '{16, 3};
  int          p_to    [2] = '{0, 100};
  int          m_cnt   [2][NA];
  int          m_mode  [2];
  int          m_quiet [2];
  int          m_agent [2];
  bit          m_fin   [2];
  bit          m_pass  [2];
  logic [63:0] m_code  [2];
  logic [63:0] m_cyc   [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NA; i++) m_cnt[m][i] = 0;
      m_mode[m] = 0; m_quiet[m] = 0; m_agent[m] = 0;
      m_fin[m] = 0; m_pass[m] = 0; m_code[m] = '0; m_cyc[m] = '0;
    end
  endtask

  task automatic verdict(int m, bit pass, logic [63:0] code, int agent);
    m_mode[m] = 3; m_fin[m] = 1; m_pass[m] = pass;
    m_code[m] = code; m_agent[m] = agent;
  endtask

  task automatic model_step(int m);
    int first_any, first_nz, err_i, total;
    logic [63:0] err_c;
    bit tmo;
    if (m_mode[m] == 3) return;
    first_any = -1; first_nz = -1; err_i = -1; err_c = '0; total = 0;
    for (int i = 0; i < NA; i++) begin
      if (done_valid[i]) begin
        if (first_any < 0) first_any = i;
        if (first_nz < 0 && done_code[64*i +: 64] != 64'd0) first_nz = i;
      end
      if (obj_raise[i] && !obj_drop[i]) begin
        if (m_cnt[m][i] == p_max[m]) begin
          if (err_i < 0) begin err_i = i; err_c = 64'hE100_0000_0000_0000 | 64'(i); end
        end else m_cnt[m][i]++;
      end else if (obj_drop[i] && !obj_raise[i]) begin
        if (m_cnt[m][i] == 0) begin
          if (err_i < 0) begin err_i = i; err_c = 64'hE000_0000_0000_0000 | 64'(i); end
        end else m_cnt[m][i]--;
      end
      total += m_cnt[m][i];
    end
    tmo = (p_to[m] != 0) && (m_cyc[m] == 64'(p_to[m] - 1));
    m_cyc[m]++;
    if (first_nz >= 0)       verdict(m, 0, done_code[64*first_nz +: 64], first_nz);
    else if (first_any >= 0) verdict(m, 1, '0, first_any);
    else if (err_i >= 0)     verdict(m, 0, err_c, err_i);
    else if (tmo)            verdict(m, 0, 64'hE200_0000_0000_0000, 0);
    else if (m_mode[m] == 0) begin
      if (total > 0) m_mode[m] = 1;
    end else if (m_mode[m] == 1) begin
      if (total == 0) begin m_mode[m] = 2; m_quiet[m] = 0; end
    end else begin
      if (total > 0) m_mode[m] = 1;
      else begin
        m_quiet[m]++;
        if (m_quiet[m] >= ((p_drain[m] > 0) ? p_drain[m] : 1)) verdict(m, 1, '0, 0);
      end
    end
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(int m, logic fin, logic pas, logic [63:0] code,
                           logic [63:0] agent, logic [63:0] st,
                           logic [63:0] outst, logic [63:0] cyc);
    int sum = 0;
    for (int i = 0; i < NA; i++) sum += m_cnt[m][i];
    n_cmp++;
    if (fin !== m_fin[m] || pas !== m_pass[m] || code !== m_code[m] ||
        agent !== 64'(m_agent[m]) || st !== 64'(m_mode[m]) ||
        outst !== 64'(sum) || cyc !== m_cyc[m]) begin
      n_bad++;
      $display("FAIL model_%0d t=%0t: got fin=%0b pass=%0b code=%0h agent=%0d st=%0d out=%0d cyc=%0d expected fin=%0b pass=%0b code=%0h agent=%0d st=%0d out=%0d cyc=%0d",
               m, $time, fin, pas, code, agent, st, outst, cyc,
               m_fin[m], m_pass[m], m_code[m], m_agent[m], m_mode[m], sum, m_cyc[m]);
    end
  endtask

  task automatic clear_inputs();
    obj_raise = '0; obj_drop = '0; done_valid = '0; done_code = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0, finish_a, passed_a, fail_code_a, 64'(agent_a), 64'(state_a),
              64'(outstanding_a), cycle_a);
    check_dut(1, finish_b, passed_b, fail_code_b, 64'(agent_b), 64'(state_b),
              64'(outstanding_b), cycle_b);
  endtask

  task automatic idle(int n);
    clear_inputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(bit check_b);
    clear_inputs();
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    if (check_b) begin
      check("rst_finish_b", 64'(finish_b), 64'd0);
      check("rst_passed_b", 64'(passed_b), 64'd0);
      check("rst_code_b", fail_code_b, 64'd0);
      check("rst_agent_b", 64'(agent_b), 64'd0);
      check("rst_state_b", 64'(state_b), 64'd0);
      check("rst_outst_b", 64'(outstanding_b), 64'd0);
      check("rst_cycle_b", cycle_b, 64'd0);
    end
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NA-1:0]    dv;
    logic [NA-1:0]    drop;
    logic [64*NA-1:0] codes;
    logic             exp_pass;
    logic [63:0]      exp_code;
    int               exp_agent;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'b1010, 4'b0000, {64'h2A, 64'h33, 64'h0, 64'h11}, 1'b0, 64'h2A, 3};
    vecs[1] = '{4'b0001, 4'b0000, {64'h0, 64'h0, 64'h0, 64'h0}, 1'b1, 64'h0, 0};
    vecs[2] = '{4'b0110, 4'b0000, {64'h7, 64'h0, 64'h0, 64'h9}, 1'b1, 64'h0, 1};
    vecs[3] = '{4'b1111, 4'b0000, {64'h0, 64'hBEEF, 64'hDEAD, 64'h0}, 1'b0, 64'hDEAD, 1};
    vecs[4] = '{4'b1000, 4'b0000, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0}, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3};
    vecs[5] = '{4'b1100, 4'b0001, {64'h0, 64'h0, 64'h5, 64'h5}, 1'b1, 64'h0, 2};
    vecs[6] = '{4'b0000, 4'b0010, {64'h0, 64'h0, 64'h0, 64'h0}, 1'b0, 64'hE000_0000_0000_0001, 1};
    vecs[7] = '{4'b0000, 4'b1100, {64'h0, 64'h0, 64'h0, 64'h0}, 1'b0, 64'hE000_0000_0000_0002, 2};

    // Done-strobe resolution and done-vs-error priority, then stickiness.
    for (int v = 0; v < 8; v++) begin
      do_reset(1'b0);
      idle(2);
      done_valid = vecs[v].dv; obj_drop = vecs[v].drop; done_code = vecs[v].codes;
      tick();
      check($sformatf("vec%0d_finish", v), 64'(finish_a), 64'd1);
      check($sformatf("vec%0d_passed", v), 64'(passed_a), 64'(vecs[v].exp_pass));
      check($sformatf("vec%0d_code", v), fail_code_a, vecs[v].exp_code);
      check($sformatf("vec%0d_agent", v), 64'(agent_a), 64'(vecs[v].exp_agent));
      done_valid = '1; done_code = {NA{64'h55}}; obj_raise = 4'b0001;
      tick();
      check($sformatf("vec%0d_sticky_code", v), fail_code_a, vecs[v].exp_code);
      check($sformatf("vec%0d_sticky_agent", v), 64'(agent_a), 64'(vecs[v].exp_agent));
      check($sformatf("vec%0d_frozen_cycle", v), cycle_a, 64'd3);
    end

    // Single objection: raise in cycle 5, drop in cycle 20, pass after edge 37.
    do_reset(1'b0);
    idle(5);
    obj_raise = 4'b0001; tick();
    idle(14);
    obj_drop = 4'b0001; tick();
    idle(15);
    check("drain_not_yet", 64'(finish_a), 64'd0);
    check("drain_state", 64'(state_a), 64'd2);
    tick();
    check("drain_finish", 64'(finish_a), 64'd1);
    check("drain_passed", 64'(passed_a), 64'd1);
    check("drain_code", fail_code_a, 64'd0);
    check("drain_agent", 64'(agent_a), 64'd0);
    check("drain_cycle", cycle_a, 64'd37);

    // Re-raise during drain cancels the pass.
    do_reset(1'b0);
    obj_raise = 4'b1010; tick();
    idle(2);
    obj_drop = 4'b1000; tick(); clear_inputs();
    check("rr_running", 64'(state_a), 64'd1);
    obj_drop = 4'b0010; tick(); clear_inputs();
    check("rr_drain", 64'(state_a), 64'd2);
    idle(5);
    obj_raise = 4'b0010; tick(); clear_inputs();
    check("rr_back_running", 64'(state_a), 64'd1);
    check("rr_outstanding", 64'(outstanding_a), 64'd1);
    idle(3);
    obj_drop = 4'b0010; tick();
    idle(15);
    check("rr_no_early_pass", 64'(finish_a), 64'd0);
    tick();
    check("rr_pass", 64'(finish_a) & 64'(passed_a), 64'd1);

    // Underflow on the same edge the watchdog would fire.
    do_reset(1'b0);
    idle(99);
    check("ut_not_yet", 64'(finish_b), 64'd0);
    obj_drop = 4'b0100; tick(); clear_inputs();
    check("ut_code_b", fail_code_b, 64'hE000_0000_0000_0002);
    check("ut_agent_b", 64'(agent_b), 64'd2);
    check("ut_cycle_b", cycle_b, 64'd100);

    // Watchdog with a held objection, then reset clears everything.
    do_reset(1'b0);
    obj_raise = 4'b0001; tick();
    idle(98);
    check("to_not_yet", 64'(finish_b), 64'd0);
    tick();
    check("to_finish", 64'(finish_b), 64'd1);
    check("to_passed", 64'(passed_b), 64'd0);
    check("to_code", fail_code_b, 64'hE200_0000_0000_0000);
    check("to_cycle", cycle_b, 64'd100);
    check("to_outstanding", 64'(outstanding_b), 64'd1);
    do_reset(1'b1);

    // Saturation of a 2-bit counter.
    obj_raise = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    check("sat_count3", 64'(outstanding_b), 64'd3);
    check("sat_no_fail", 64'(finish_b), 64'd0);
    tick(); clear_inputs();
    check("sat_code", fail_code_b, 64'hE100_0000_0000_0000);
    check("sat_held", 64'(outstanding_b), 64'd3);
    check("sat_wide_counts", 64'(outstanding_a), 64'd4);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 30; ep++) begin
      do_reset(1'b0);
      for (int c = 0; c < 250; c++) begin
        if (m_fin[0] && m_fin[1]) break;
        clear_inputs();
        for (int i = 0; i < NA; i++) begin
          if (c < 100) obj_raise[i] = ($urandom_range(3) == 0);
          else         obj_raise[i] = ($urandom_range(19) == 0);
          if (m_cnt[0][i] > 0) obj_drop[i] = ($urandom_range((c < 100) ? 5 : 2) == 0);
          else                 obj_drop[i] = ($urandom_range(99) == 0);
          if ($urandom_range(299) == 0) begin
            done_valid[i] = 1'b1;
            done_code[64*i +: 64] = $urandom_range(1) ? {$urandom, $urandom} : 64'd0;
          end
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
